if_stage: RTL and testbench

Instruction fetch stage of the RISC-V core. It holds the program counter and issues word-aligned fetch requests to instruction memory. Returned instruction words are buffered in a small in-order FIFO and presented with their PC to decode, where the immediate generator consumes `inst`. Taken branches and jumps redirect the stage through a single redirect port, and in-flight stale responses are discarded.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/if_fifo.sv | 63 ++++++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Types and constants shared by fetch, decode and the immediate generator.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_fifo.sv
// In-order instruction buffer of {pc, inst}; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module if_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  fetch_entry_t               data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output fetch_entry_t               head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   fetch_entry_t mem_q [DEPTH];
   logic         do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_ONE;
         if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is data only; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

   assign count_o = wptr_q - rptr_q;
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign head_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/if_stage.sv
// RISC-V instruction fetch stage: credit-limited fetch, in-order buffer, redirect
// with stale-response dropping. Optional misaligned-target trap: IF_MISALIGN_TRAP_EN.
module if_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_misaligned
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            halted_q, halted_d;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            fifo_push;
   fetch_entry_t    push_entry, head_entry;

   logic [CW:0]     credit;
   logic            req_fire, resp_drop, pop_fire;
   logic [XLEN-1:0] resp_tag;
   logic [XLEN-1:0] redir_target;
   logic            redir_misaligned;

`ifdef IF_MISALIGN_TRAP_EN
   assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
   assign fetch_misaligned = halted_q;
`else
   assign redir_misaligned = 1'b0;
   assign fetch_misaligned = 1'b0;
`endif
   assign redir_target = align_word(redirect_pc);

   // A pop this cycle frees a slot immediately, sustaining one fetch per cycle.
   assign pop_fire = !fifo_empty && inst_ready;
   assign credit   = {1'b0, outst_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop_fire};

   assign imem_req_valid = !rst && !halted_q && (credit < DEPTH_C);
   assign imem_req_addr  = fpc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Live requests since the last redirect are contiguous and end at fpc.
   assign resp_drop = imem_resp_valid && (drop_q != '0);
   assign resp_tag  = fpc_q - (XLEN'(outst_q - drop_q) << 2);

   assign fifo_push       = imem_resp_valid && !resp_drop && !redirect_valid;
   assign push_entry.pc   = resp_tag;
   assign push_entry.inst = imem_resp_data;

   always_comb begin
      fpc_d    = fpc_q;
      outst_d  = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      drop_d   = drop_q - CW'(resp_drop);
      halted_d = halted_q;
      if (req_fire) fpc_d = fpc_q + XLEN'(4);
      // Every request still outstanding after this edge predates the redirect.
      if (redirect_valid) begin
         fpc_d    = redir_target;
         drop_d   = outst_d;
         halted_d = redir_misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q    <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         fpc_q    <= fpc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         halted_q <= halted_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(imem_resp_valid && (outst_q == '0)));
   end

   if_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (push_entry),
      .pop_i   (pop_fire),
      .flush_i (redirect_valid),
      .head_o  (head_entry),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign inst_valid = !fifo_empty;
   assign inst       = fifo_empty ? '0 : head_entry.inst;
   assign pc         = fifo_empty ? fpc_q : head_entry.pc;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model with configurable latency and
// an in-order scoreboard of expected {pc, inst} pairs.
module tb_if_stage;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misaligned;

   always #5 clk = ~clk;

   if_stage #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid   (imem_req_valid),
      .imem_req_addr    (imem_req_addr),
      .imem_req_ready   (imem_req_ready),
      .imem_resp_valid  (imem_resp_valid),
      .imem_resp_data   (imem_resp_data),
      .inst_valid       (inst_valid),
      .inst             (inst),
      .pc               (pc),
      .inst_ready       (inst_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .fetch_misaligned (fetch_misaligned)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } pend_t;

   pend_t        pend[$];
   fetch_entry_t exp_q[$];
   logic [31:0]  req_log[$];
   logic [31:0]  pop_log[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc, lat, n_pop, first_pop_cyc;
   logic [31:0]  exp_fpc;
   logic         exp_halted;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   // One cycle: drive memory response, score outputs, log requests, advance.
   task automatic step();
      fetch_entry_t e;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = pend[0].data;
         void'(pend.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      #1;
      if (inst_valid && inst_ready) begin
         n_pop++;
         pop_log.push_back(pc);
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected cyc=%0d got pc=%h inst=%h expected none", cyc, pc, inst);
         end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc || inst !== e.inst) begin
               errors++;
               $display("FAIL sb_output cyc=%0d got pc=%h inst=%h expected pc=%h inst=%h",
                        cyc, pc, inst, e.pc, e.inst);
            end
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         checks++;
         if (exp_halted || imem_req_addr !== exp_fpc) begin
            errors++;
            $display("FAIL req_addr cyc=%0d got %h expected %h halted=%0d",
                     cyc, imem_req_addr, exp_fpc, exp_halted);
         end
         pend.push_back('{due: cyc + lat, data: mem_word(imem_req_addr)});
         req_log.push_back(imem_req_addr);
         exp_q.push_back('{pc: exp_fpc, inst: mem_word(exp_fpc)});
         exp_fpc = exp_fpc + 32'd4;
      end
      if (redirect_valid) begin
         exp_q.delete();
         exp_fpc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_TRAP_EN
         exp_halted = (redirect_pc[1:0] != 2'b00);
`endif
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      inst_ready      = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_req_ready  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      pend.delete();
      exp_q.delete();
      req_log.delete();
      pop_log.delete();
      exp_fpc       = RST_PC;
      exp_halted    = 1'b0;
      first_pop_cyc = -1;
      n_pop         = 0;
      cyc           = 0;
      rst           = 1'b0;
   endtask

   task automatic redirect_step(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic check_pop(input string name, input int idx, input logic [31:0] want);
      checks++;
      if (pop_log.size() <= idx) begin
         errors++;
         $display("FAIL %s got no output (count=%0d) expected pc=%h", name, pop_log.size(), want);
      end else if (pop_log[idx] !== want) begin
         errors++;
         $display("FAIL %s got pc=%h expected pc=%h", name, pop_log[idx], want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = '0; imem_req_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b expected 0", imem_req_valid); end
      checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_req_addr got %h expected %h", imem_req_addr, RST_PC); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b expected 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h expected 0", inst); end
      checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc got %h expected %h", pc, RST_PC); end
      checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned got %b expected 0", fetch_misaligned); end
   endtask

   task automatic test_stream();
      do_reset();
      lat = 1; inst_ready = 1'b1;
      run(14);
      checks++; if (first_pop_cyc != 2) begin errors++; $display("FAIL stream_first_valid got cycle %0d expected 2", first_pop_cyc); end
      checks++; if (n_pop != 12) begin errors++; $display("FAIL stream_throughput got %0d pops expected 12", n_pop); end
      checks++; if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
         errors++; $display("FAIL stream_req_order got %0d requests expected 0,4,8 first", req_log.size());
      end
      check_pop("stream_pc0", 0, 32'h0);
      check_pop("stream_pc1", 1, 32'h4);
      // mid-operation reset
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_inst_valid got %b expected 0", inst_valid); end
      checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL midrst_req_addr got %h expected %h", imem_req_addr, RST_PC); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid got %b expected 0", imem_req_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat = 1; inst_ready = 1'b0;
      run(5);
      checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_outstanding got %0d requests expected 2", req_log.size()); end
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin
         errors++; $display("FAIL bp_hold got valid=%b pc=%h expected valid=1 pc=0", inst_valid, pc);
      end
      inst_ready = 1'b1;
      run(6);
      check_pop("bp_pc0", 0, 32'h0);
      check_pop("bp_pc1", 1, 32'h4);
      check_pop("bp_pc2", 2, 32'h8);
   endtask

   task automatic test_redirect_latency();
      int mark, rcyc;
      do_reset();
      lat = 3; inst_ready = 1'b1;
      run(2);
      rcyc = cyc;
      redirect_step(32'h0000_0100);
      mark = pop_log.size();
      checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_lat_addr got %h expected 00000100", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_lat_valid got %b expected 0", inst_valid); end
      run(14);
      check_pop("redir_lat_first", mark, 32'h100);
      checks++; if (first_pop_cyc < rcyc + 1 + lat + 1) begin
         errors++; $display("FAIL redir_lat_timing got cycle %0d expected >= %0d", first_pop_cyc, rcyc + 1 + lat + 1);
      end
   endtask

   task automatic test_redirect_collide();
      int mark, pops_before;
      do_reset();
      lat = 1; inst_ready = 1'b1;
      run(5);
      pops_before = n_pop;
      redirect_step(32'h0000_0200);
      mark = pop_log.size();
      checks++; if (imem_resp_valid !== 1'b1) begin errors++; $display("FAIL collide_resp got %b expected 1", imem_resp_valid); end
      checks++; if (n_pop != pops_before + 1) begin errors++; $display("FAIL collide_pop got %0d pops expected %0d", n_pop, pops_before + 1); end
      checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL collide_addr got %h expected 00000200", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_valid got %b expected 0", inst_valid); end
      run(6);
      check_pop("collide_first", mark, 32'h200);
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 1; inst_ready = 1'b1;
      redirect_step(32'hFFFF_FFFC);
      run(6);
      checks++; if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_req got %0d requests expected FFFFFFFC then 00000000", req_log.size());
      end
      check_pop("wrap_pc0", 0, 32'hFFFF_FFFC);
      check_pop("wrap_pc1", 1, 32'h0000_0000);
   endtask

   task automatic test_back_to_back();
      int mark;
      do_reset();
      lat = 3; inst_ready = 1'b1;
      run(1);
      redirect_step(32'h0000_0300);
      redirect_step(32'h0000_0400);
      mark = pop_log.size();
      checks++; if (imem_req_addr !== 32'h400) begin errors++; $display("FAIL b2b_addr got %h expected 00000400", imem_req_addr); end
      run(12);
      check_pop("b2b_first", mark, 32'h400);
   endtask

   task automatic test_misalign();
      int mark;
      do_reset();
      lat = 1; inst_ready = 1'b1;
      run(3);
      redirect_step(32'h0000_0102);
`ifdef IF_MISALIGN_TRAP_EN
      checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag_set got %b expected 1", fetch_misaligned); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_halt cyc=%0d got req_valid=%b expected 0", cyc, imem_req_valid); end
         step();
      end
      redirect_step(32'h0000_0104);
      mark = pop_log.size();
      checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_flag_clear got %b expected 0", fetch_misaligned); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
         errors++; $display("FAIL mis_resume got valid=%b addr=%h expected valid=1 addr=00000104", imem_req_valid, imem_req_addr);
      end
      run(5);
      check_pop("mis_first", mark, 32'h104);
`else
      mark = pop_log.size();
      checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_flag got %b expected 0", fetch_misaligned); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         errors++; $display("FAIL mis_align got valid=%b addr=%h expected valid=1 addr=00000100", imem_req_valid, imem_req_addr);
      end
      run(5);
      check_pop("mis_first", mark, 32'h100);
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_collide();
      test_wrap();
      test_back_to_back();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
